// File: rtl/note_seq_if.sv
// Signal bundle linking the note sequencer to its host controls, the song ROM
// and the tone generator. master = host/ROM side, slave = sequencer.
interface note_seq_if #(
  parameter int ADDR_W = 8,
  parameter int NOTE_W = 5,
  parameter int DUR_W  = 4
) ();
  // start/stop are single-cycle pulses and pause is a level, all sampled on clk.
  // rom_data answers rom_addr one cycle later; done and tick are one-cycle pulses.
  logic                    start;
  logic                    stop;
  logic                    pause;
  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic                    note_vld;
  logic                    busy;
  logic                    done;
  logic                    tick;

  modport master (
    output start, stop, pause, rom_data,
    input  rom_addr, note, note_vld, busy, done, tick
  );

  modport slave (
    input  start, stop, pause, rom_data,
    output rom_addr, note, note_vld, busy, done, tick
  );
endinterface

// File: rtl/note_sequencer.sv
// Tempo-driven song playback: fetches {note, dur} entries and holds each note for dur ticks.
// Define NOTE_SEQ_LOOP_EN to restart at address 0 on end-of-song instead of stopping.
module note_sequencer #(
  parameter int TICK_DIV  = 10201,
  parameter int ADDR_W    = 8,
  parameter int NOTE_W    = 5,
  parameter int DUR_W     = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  note_seq_if.slave  bus,
  output logic [2:0] state_dbg
);
  localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX    = GAP_W'(GAP_LAST);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [NOTE_W-1:0]  note_q,  note_d;
  logic [DUR_W-1:0]   rem_q,   rem_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               done_q,  done_d;

  logic               run;
  logic               tick;
  logic               advance;
  logic               song_end;
  logic [NOTE_W-1:0]  rd_note;
  logic [DUR_W-1:0]   rd_dur;

  assign {rd_note, rd_dur} = bus.rom_data;

  // Prescaler only advances while playing and not paused; that freezes every tick-driven count.
  assign run  = (state_q != S_IDLE) && !bus.pause;
  assign tick = run && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    advance  = 1'b0;
    song_end = 1'b0;

    if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (rd_dur == '0) begin
          song_end = 1'b1;
        end else begin
          note_d  = rd_note;
          rem_d   = rd_dur;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (rem_q == DUR_W'(1)) begin
            note_d = '0;
            if (GAP_TICKS == 0) begin
              advance = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end else begin
            rem_d = rem_q - DUR_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_MAX) advance = 1'b1;
          else                  gap_d   = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Running off the top of the ROM is treated exactly like an end-of-song marker.
    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        song_end = 1'b1;
      end else begin
        state_d = S_FETCH;
        addr_d  = addr_q + ADDR_W'(1);
      end
    end

    if (song_end) begin
      done_d = 1'b1;
      note_d = '0;
      addr_d = '0;
`ifdef NOTE_SEQ_LOOP_EN
      state_d = S_FETCH;
`else
      state_d = S_IDLE;
      cnt_d   = '0;
`endif
    end

    if (bus.stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      note_d  = '0;
      rem_d   = '0;
      gap_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.note     = note_q;
  assign bus.note_vld = (state_q == S_PLAY) && (note_q != '0);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.tick     = tick;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, ADDR_W=2, GAP_TICKS=1 and a 4-entry ROM.
// Cycle k means the k-th cycle after the edge that samples start; outputs are read at negedge.
module tb_note_sequencer;
  localparam int TICK_DIV  = 4;
  localparam int ADDR_W    = 2;
  localparam int NOTE_W    = 5;
  localparam int DUR_W     = 4;
  localparam int GAP_TICKS = 1;
  localparam int EW        = NOTE_W + DUR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    state_dbg;
  logic [EW-1:0] rom [0:3];
  logic [10:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  note_seq_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

  note_sequencer #(
    .TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
    .DUR_W(DUR_W), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous song ROM: data one cycle after address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // driver tasks
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic load_rom(input logic [EW-1:0] e0, e1, e2, e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  function automatic logic [10:0] obs_word();
    return {bus.busy, bus.note_vld, bus.note, bus.done, bus.tick, bus.rom_addr};
  endfunction

  task automatic test_reset();
    adv(2);
    n_checks++;
    if (obs_word() !== 11'd0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs %h state %0d, expected 0 and 0", obs_word(), state_dbg);
    end
    rst_n = 1'b1;
    adv(1);
    n_checks++;
    if (obs_word() !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_release: outputs %h, expected 000", obs_word());
    end
  endtask

  // {5,2},{7,1},{0,0}: note 5 k3..8, gap k9..12, note 7 k15..16, gap, done k23
  task automatic test_basic();
    logic [10:0] obs, exp;
    logic [4:0]  en;
    logic [1:0]  ea;
    load_rom({5'd5, 4'd2}, {5'd7, 4'd1}, 9'd0, 9'd0);
    for (int k = 1; k <= 24; k++) begin
      en = (k >= 3 && k <= 8) ? 5'd5 : (k == 15 || k == 16) ? 5'd7 : 5'd0;
      ea = (k >= 13 && k <= 20) ? 2'd1 : (k == 21 || k == 22) ? 2'd2 : 2'd0;
      exp_q.push_back({k <= 22, en != 5'd0, en, k == 23, (k % 4 == 0) && (k <= 22), ea});
    end
    do_start();
    for (int k = 1; k <= 24; k++) begin
      obs = obs_word();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL basic k=%0d: {busy,vld,note,done,tick,addr} got %h expected %h", k, obs, exp);
      end
      adv(1);
    end
  endtask

  task automatic test_rest();
    load_rom({5'd0, 4'd3}, {5'd7, 4'd1}, 9'd0, 9'd0);
    do_start();
    for (int k = 1; k <= 18; k++) begin
      n_checks++;
      if (bus.note_vld !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rest k=%0d: vld %b busy %b, expected vld 0 busy 1", k, bus.note_vld, bus.busy);
      end
      adv(1);
    end
    n_checks++;
    if ({bus.note_vld, bus.note, bus.rom_addr} !== {1'b1, 5'd7, 2'd1}) begin
      n_fail++;
      $display("FAIL rest_next: vld %b note %0d addr %0d, expected 1 7 1", bus.note_vld, bus.note, bus.rom_addr);
    end
    adv(8);
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL rest_done: done %b busy %b, expected 1 0", bus.done, bus.busy);
    end
    adv(1);
  endtask

  // pause high across edges k6..k15 stretches note 5 from 6 to 16 cycles
  task automatic test_pause();
    int len = 0;
    load_rom({5'd5, 4'd2}, {5'd7, 4'd1}, 9'd0, 9'd0);
    do_start();
    for (int k = 1; k <= 20; k++) begin
      if (bus.note_vld && bus.note == 5'd5) len++;
      if (k >= 6 && k <= 15) begin
        n_checks++;
        if (bus.tick !== 1'b0 || bus.note_vld !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_hold k=%0d: tick %b vld %b, expected 0 1", k, bus.tick, bus.note_vld);
        end
      end
      if (k == 18) begin
        n_checks++;
        if (bus.tick !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_resume_tick k=18: tick %b, expected 1", bus.tick);
        end
      end
      bus.pause = (k >= 5 && k <= 14);
      adv(1);
    end
    n_checks++;
    if (len != 16) begin
      n_fail++;
      $display("FAIL pause_len: note 5 sounded %0d cycles, expected 16", len);
    end
    do_stop();
    adv(2);
  endtask

  task automatic test_stop();
    load_rom({5'd5, 4'd2}, {5'd7, 4'd1}, 9'd0, 9'd0);
    do_start();
    for (int k = 1; k <= 15; k++) begin
      if (k == 6) begin
        n_checks++;
        if ({bus.note_vld, bus.note} !== {1'b1, 5'd5}) begin
          n_fail++;
          $display("FAIL start_ignored k=6: vld %b note %0d, expected 1 5", bus.note_vld, bus.note);
        end
      end
      if (k == 15) begin
        n_checks++;
        if ({bus.note_vld, bus.note, bus.rom_addr} !== {1'b1, 5'd7, 2'd1}) begin
          n_fail++;
          $display("FAIL stop_pre k=15: vld %b note %0d addr %0d, expected 1 7 1", bus.note_vld, bus.note, bus.rom_addr);
        end
      end
      bus.start = (k == 5);
      bus.stop  = (k == 15);
      adv(1);
    end
    bus.stop = 1'b0;
    n_checks++;
    if ({bus.busy, bus.note_vld, bus.note, bus.rom_addr} !== 9'd0) begin
      n_fail++;
      $display("FAIL stop_clear: busy %b vld %b note %0d addr %0d, expected all 0", bus.busy, bus.note_vld, bus.note, bus.rom_addr);
    end
    for (int k = 0; k < 5; k++) begin
      adv(1);
      n_checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL stop_no_done +%0d: done %b busy %b, expected 0 0", k + 1, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_start_stop();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    adv(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    n_checks++;
    if ({bus.busy, bus.rom_addr, state_dbg} !== 6'd0) begin
      n_fail++;
      $display("FAIL start_stop: busy %b addr %0d state %0d, expected 0 0 0", bus.busy, bus.rom_addr, state_dbg);
    end
    for (int k = 0; k < 4; k++) begin
      adv(1);
      n_checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL start_stop_idle +%0d: done %b busy %b, expected 0 0", k + 1, bus.done, bus.busy);
      end
    end
  endtask

  // all entries {3,1}: FETCH of addr 3 at k25, end of pass at k33
  task automatic test_wrap();
    load_rom({5'd3, 4'd1}, {5'd3, 4'd1}, {5'd3, 4'd1}, {5'd3, 4'd1});
    do_start();
    for (int k = 1; k <= 32; k++) begin
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_early_done k=%0d: done %b, expected 0", k, bus.done);
      end
      if (k == 25) begin
        n_checks++;
        if ({bus.busy, bus.rom_addr} !== {1'b1, 2'd3}) begin
          n_fail++;
          $display("FAIL wrap_addr3 k=25: busy %b addr %0d, expected 1 3", bus.busy, bus.rom_addr);
        end
      end
      adv(1);
    end
    n_checks++;
`ifdef NOTE_SEQ_LOOP_EN
    if ({bus.done, bus.busy, bus.rom_addr} !== {1'b1, 1'b1, 2'd0}) begin
`else
    if ({bus.done, bus.busy, bus.rom_addr} !== {1'b1, 1'b0, 2'd0}) begin
`endif
      n_fail++;
      $display("FAIL wrap_end k=33: done %b busy %b addr %0d", bus.done, bus.busy, bus.rom_addr);
    end
    adv(1);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done_width k=34: done %b, expected 0", bus.done);
    end
    do_stop();
    adv(2);
  endtask

  task automatic test_reset_gap();
    load_rom({5'd5, 4'd2}, {5'd7, 4'd1}, 9'd0, 9'd0);
    do_start();
    adv(16);
    n_checks++;
    if ({bus.busy, bus.note_vld, bus.rom_addr} !== {1'b1, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL reset_gap_pre k=17: busy %b vld %b addr %0d, expected 1 0 1", bus.busy, bus.note_vld, bus.rom_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_word() !== 11'd0 || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_async: outputs %h state %0d, expected 0 and 0", obs_word(), state_dbg);
    end
    adv(2);
    rst_n = 1'b1;
    adv(1);
    do_start();
    n_checks++;
    if ({bus.busy, bus.rom_addr} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL replay_fetch k=1: busy %b addr %0d, expected 1 0", bus.busy, bus.rom_addr);
    end
    adv(2);
    n_checks++;
    if ({bus.note_vld, bus.note} !== {1'b1, 5'd5}) begin
      n_fail++;
      $display("FAIL replay_note k=3: vld %b note %0d, expected 1 5", bus.note_vld, bus.note);
    end
    do_stop();
    adv(2);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    load_rom(9'd0, 9'd0, 9'd0, 9'd0);
    test_reset();
    test_basic();
    test_rest();
    test_pause();
    test_stop();
    test_start_stop();
    test_wrap();
    test_reset_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
